pc_redirect_unit: RTL and testbench

Fetch-side consumer of the branch/jump redirect request (redirect_valid + redirect_target) from the EX-stage branch controller. It owns the program counter and advances it by 4 or loads the redirect target. It buffers a redirect that arrives while the pipeline is stalled, and issues one-cycle flush pulses to the IF/ID and ID/EX pipeline registers. Misaligned targets trap into a sticky fault state.

---
 rtl/pc_redirect_unit_if.sv | 31 +++
 rtl/pc_redirect_unit.sv | 107 ++++++++++
 tb/tb_pc_redirect_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// Redirect request and fetch-side status bundle for pc_redirect_unit.
// master: the side that issues stall/ready/redirect and observes the PC.
// slave : the PC redirect unit itself.
interface pc_redirect_unit_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 stall;
  logic                 imem_ready;
  logic                 redirect_valid;
  logic [31:0]          redirect_target;
  logic [31:0]          pc_out;
  logic [31:0]          pc_plus4;
  logic                 if_valid;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 misalign_fault;
  logic                 pending;
  logic [CNT_WIDTH-1:0] redirect_count;

  modport master (
    output stall, imem_ready, redirect_valid, redirect_target,
    input  pc_out, pc_plus4, if_valid, flush_ifid, flush_idex,
           misalign_fault, pending, redirect_count
  );

  modport slave (
    input  stall, imem_ready, redirect_valid, redirect_target,
    output pc_out, pc_plus4, if_valid, flush_ifid, flush_idex,
           misalign_fault, pending, redirect_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter owner for the fetch stage. Advances by 4, applies
// branch/jump redirects, buffers a redirect that arrives while fetch is
// frozen, emits one-cycle flush pulses and traps misaligned targets in a
// sticky fault state.
module pc_redirect_unit #(
  parameter logic [31:0]  RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned  CNT_WIDTH    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_redirect_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          pend_q, pend_d;
  logic                 flush_q, flush_d;
  logic                 if_valid_q;
  logic                 apply;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 adv;

  assign adv = !bus.stall && bus.imem_ready;

  // Next-state, next-PC and redirect application
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    apply   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          // Alignment trap wins over advancing
          if (bus.redirect_target[1:0] != 2'b00) begin
            state_d = FAULT;
          end else if (adv) begin
            pc_d    = bus.redirect_target;
            flush_d = 1'b1;
            apply   = 1'b1;
          end else begin
            pend_d  = bus.redirect_target;
            state_d = HOLD;
          end
        end else if (adv) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HOLD: begin
        // New redirects belong to younger instructions and are dropped
        if (adv) begin
          pc_d    = pend_q;
          pend_d  = '0;
          flush_d = 1'b1;
          apply   = 1'b1;
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
    cnt_d = cnt_q;
    if (apply && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      if_valid_q <= (state_d != FAULT);
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.pc_plus4       = pc_q + 32'd4;
  assign bus.if_valid       = if_valid_q;
  assign bus.flush_ifid     = flush_q;
  assign bus.flush_idex     = flush_q;
  assign bus.misalign_fault = (state_q == FAULT);
  assign bus.pending        = (state_q == HOLD);
  assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with a transaction-level reference
// model and literal expectations at key points.
module tb_pc_redirect_unit;
  localparam int unsigned CW = 3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pc_redirect_unit_if #(.CNT_WIDTH(CW)) bus ();

  pc_redirect_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_has_pend;
  logic [31:0] m_pend_tgt;
  logic        m_fault;
  logic        m_flush;
  logic        m_ifv;
  int          m_cnt;

  task automatic model_reset();
    m_pc       = 32'h0;
    m_has_pend = 1'b0;
    m_pend_tgt = 32'h0;
    m_fault    = 1'b0;
    m_flush    = 1'b0;
    m_ifv      = 1'b0;
    m_cnt      = 0;
  endtask

  task automatic redirect_applied(input logic [31:0] t);
    m_pc    = t;
    m_flush = 1'b1;
    if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic rv,
                            input logic [31:0] t);
    logic go;
    go      = !s && r;
    m_flush = 1'b0;
    if (m_fault) begin
      // absorbing
    end else if (m_has_pend) begin
      if (go) begin
        redirect_applied(m_pend_tgt);
        m_has_pend = 1'b0;
      end
    end else if (rv) begin
      if (t % 4 != 0) m_fault = 1'b1;
      else if (go) redirect_applied(t);
      else begin
        m_has_pend = 1'b1;
        m_pend_tgt = t;
      end
    end else if (go) begin
      m_pc = m_pc + 32'd4;
    end
    m_ifv = !m_fault;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("pc_out",         bus.pc_out,                 m_pc);
    chk("pc_plus4",       bus.pc_plus4,               m_pc + 32'd4);
    chk("if_valid",       32'(bus.if_valid),          32'(m_ifv));
    chk("flush_ifid",     32'(bus.flush_ifid),        32'(m_flush));
    chk("flush_idex",     32'(bus.flush_idex),        32'(m_flush));
    chk("misalign_fault", 32'(bus.misalign_fault),    32'(m_fault));
    chk("pending",        32'(bus.pending),           32'(m_has_pend));
    chk("redirect_count", 32'(bus.redirect_count),    32'(m_cnt));
  endtask

  // One clock: drive inputs, take the edge, advance model, compare
  task automatic step(input logic s, input logic r, input logic rv,
                      input logic [31:0] t);
    bus.stall           = s;
    bus.imem_ready      = r;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
    @(posedge clk);
    model_edge(s, r, rv, t);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    chk("rst_pc_lit",  bus.pc_out, 32'h0);
    chk("rst_pend_lit", 32'(bus.pending), 32'h0);
    chk("rst_flush_lit", 32'(bus.flush_ifid), 32'h0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.stall           = 1'b0;
    bus.imem_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    model_reset();
    #12;
    compare_model();
    chk("init_ifv_lit", 32'(bus.if_valid), 32'h0);
    chk("init_cnt_lit", 32'(bus.redirect_count), 32'h0);
    #1 rst_n = 1'b1;

    // Sequential fetch
    step(0, 1, 0, 32'h0);
    chk("seq1_lit", bus.pc_out, 32'h4);
    chk("ifv_first_edge_lit", 32'(bus.if_valid), 32'h1);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    chk("seq3_lit", bus.pc_out, 32'hC);
    step(0, 1, 0, 32'h0);
    chk("pc10_lit", bus.pc_out, 32'h10);

    // Immediate redirect
    step(0, 1, 1, 32'h100);
    chk("redir_pc_lit", bus.pc_out, 32'h100);
    chk("redir_flush_lit", 32'(bus.flush_idex), 32'h1);
    chk("redir_cnt_lit", 32'(bus.redirect_count), 32'h1);
    step(0, 1, 0, 32'h0);
    chk("after_redir_pc_lit", bus.pc_out, 32'h104);
    chk("after_redir_flush_lit", 32'(bus.flush_ifid), 32'h0);

    // Buffered redirect under stall; second redirect ignored
    step(1, 1, 1, 32'h200);
    chk("hold_pend_lit", 32'(bus.pending), 32'h1);
    step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h300);
    chk("hold_pc_lit", bus.pc_out, 32'h104);
    step(0, 1, 0, 32'h0);
    chk("release_pc_lit", bus.pc_out, 32'h200);
    chk("release_flush_lit", 32'(bus.flush_ifid), 32'h1);
    chk("release_cnt_lit", 32'(bus.redirect_count), 32'h2);
    step(0, 1, 0, 32'h0);
    chk("release_flush_off_lit", 32'(bus.flush_ifid), 32'h0);

    // Buffered by imem not ready; HOLD ignores new redirect; back-to-back
    step(0, 0, 1, 32'h500);
    step(0, 1, 1, 32'h600);
    chk("hold_imem_pc_lit", bus.pc_out, 32'h500);
    step(0, 1, 1, 32'h700);
    chk("b2b_pc_lit", bus.pc_out, 32'h700);
    chk("b2b_flush_lit", 32'(bus.flush_ifid), 32'h1);

    // Counter saturation (3-bit counter here)
    for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h800 + 32'(i) * 32'h10);
    chk("cnt_sat_lit", 32'(bus.redirect_count), 32'h7);

    // PC wrap
    step(0, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 32'h0);
    chk("wrap_pc_lit", bus.pc_out, 32'h0);
    chk("wrap_plus4_lit", bus.pc_plus4, 32'h4);

    // Reset during HOLD discards pending target
    step(1, 1, 1, 32'h400);
    chk("hold400_lit", 32'(bus.pending), 32'h1);
    do_reset();
    step(0, 1, 0, 32'h0);
    chk("post_rst_pc_lit", bus.pc_out, 32'h4);
    chk("post_rst_flush_lit", 32'(bus.flush_ifid), 32'h0);

    // Misaligned target -> sticky fault
    step(0, 1, 1, 32'h102);
    chk("fault_lit", 32'(bus.misalign_fault), 32'h1);
    chk("fault_ifv_lit", 32'(bus.if_valid), 32'h0);
    chk("fault_pc_lit", bus.pc_out, 32'h4);
    step(0, 1, 1, 32'h900);
    step(0, 1, 0, 32'h0);
    step(1, 0, 1, 32'h3);
    chk("fault_hold_pc_lit", bus.pc_out, 32'h4);
    chk("fault_plus4_lit", bus.pc_plus4, 32'h8);
    do_reset();
    step(0, 1, 0, 32'h0);

    // Misaligned target wins even while stalled
    step(1, 0, 1, 32'h1);
    chk("fault_stall_lit", 32'(bus.misalign_fault), 32'h1);
    chk("fault_stall_pend_lit", 32'(bus.pending), 32'h0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
